// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default address width, PC source select encodings and
// the CALL/RET opcodes the control unit decodes into return-stack push/pop.
package cpu_pkg;

  localparam int unsigned CpuAddrW = 32;

  typedef enum logic [1:0] {
    PC_Src_Dft = 2'd0,
    PC_Src_BTA = 2'd1,
    PC_Src_JMP = 2'd2,
    PC_Src_Ra  = 2'd3
  } pc_src_e;

  localparam logic [5:0] OpCall = 6'h03;
  localparam logic [5:0] OpRet  = 6'h07;

endpackage

// File: rtl/ras_mem.sv
// Return-address storage: DEPTH x ADDR_W registers, one synchronous write port and
// one asynchronous read port. Contents are not reset.
module ras_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_stack.sv
// Call/return address stack feeding the PC block. Top-of-stack is combinational.
// Define RAS_CIRCULAR_EN to let a push while full overwrite the oldest entry.
module return_stack
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = CpuAddrW,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] return_address,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W:0]    FullCnt = {1'b1, {PTR_W{1'b0}}};
  localparam logic [PTR_W-1:0]  PtrOne  = PTR_W'(1);
  localparam logic [PTR_W:0]    CntOne  = (PTR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [PTR_W-1:0]  top_ptr;
  logic [ADDR_W-1:0] mem_rdata;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCnt);
  assign top_ptr = sp_q - PtrOne;

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = sp_q;

    if (push && pop && !empty) begin
      // Simultaneous CALL/RET replaces the top entry in place.
      mem_we    = 1'b1;
      mem_waddr = top_ptr;
    end else if (push) begin
      if (pop) begin
        underflow_d = 1'b1;
      end
      if (!full) begin
        mem_we  = 1'b1;
        sp_d    = sp_q + PtrOne;
        count_d = count_q + CntOne;
      end else begin
        overflow_d = 1'b1;
`ifdef RAS_CIRCULAR_EN
        // sp wraps, so the write lands on the oldest entry.
        mem_we = 1'b1;
        sp_d   = sp_q + PtrOne;
`endif
      end
    end else if (pop) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        sp_d    = top_ptr;
        count_d = count_q - CntOne;
      end
    end

    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  ras_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ras_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (pc_in + AddrOne),
    .raddr (top_ptr),
    .rdata (mem_rdata)
  );

  assign return_address = empty ? '0 : mem_rdata;
  assign count          = count_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

endmodule
